// File: rtl/flag_cond_pkg.sv
// Shared definitions for the flag conditioner: debouncer state encoding,
// channel indices and the debounce counter width.
package flag_cond_pkg;

    typedef enum logic [1:0] {
        LO_STABLE = 2'b00,
        LO_TO_HI  = 2'b01,
        HI_STABLE = 2'b11,
        HI_TO_LO  = 2'b10
    } db_state_e;

    localparam int CH_M  = 0;
    localparam int CH_SL = 1;
    localparam int CH_SG = 2;
    localparam int CH_LS = 3;
    localparam int CH_LC = 4;
    localparam int CH_SE = 5;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/flag_debounce_ch.sv
// One conditioned channel: 2-FF synchronizer, 4-state debounce FSM with
// run counter, registered edge pulses and a sticky rise event.
module flag_debounce_ch
    import flag_cond_pkg::*;
#(
    parameter int   DB_CYCLES = 1000000,
    parameter logic RST_BIT   = 1'b0
) (
    input  logic ck,
    input  logic rst_n,
    input  logic raw,
    input  logic evt_clr,
    output logic flag,
    output logic rise,
    output logic fall,
    output logic evt
);

    localparam int CNT_W = cnt_width(DB_CYCLES);
    localparam db_state_e RST_STATE = RST_BIT ? HI_STABLE : LO_STABLE;

    logic [1:0]       sync_q, sync_d;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             evt_q, evt_d;
    logic             s;
    logic             last;

    assign s    = sync_q[1];
    assign last = (cnt_q == CNT_W'(DB_CYCLES - 1));

    always_comb begin
        sync_d  = {sync_q[0], raw};
        state_d = state_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            LO_STABLE: if (s) begin
                // A single-cycle debounce window skips the counting state.
                if (DB_CYCLES == 1) begin
                    state_d = HI_STABLE;
                    rise_d  = 1'b1;
                end else begin
                    state_d = LO_TO_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            LO_TO_HI: begin
                if (!s) begin
                    state_d = LO_STABLE;
                end else if (last) begin
                    state_d = HI_STABLE;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HI_STABLE: if (!s) begin
                if (DB_CYCLES == 1) begin
                    state_d = LO_STABLE;
                    fall_d  = 1'b1;
                end else begin
                    state_d = HI_TO_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            HI_TO_LO: begin
                if (s) begin
                    state_d = HI_STABLE;
                end else if (last) begin
                    state_d = LO_STABLE;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RST_STATE;
        endcase
        // Set beats clear so a rise coinciding with a clear is never lost.
        evt_d = rise_d | (evt_q & ~evt_clr);
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {2{RST_BIT}};
            state_q <= RST_STATE;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            evt_q   <= evt_d;
        end
    end

    // The upper state bit is the clean level by encoding.
    assign flag = state_q[1];
    assign rise = rise_q;
    assign fall = fall_q;
    assign evt  = evt_q;

endmodule

// File: rtl/flag_conditioner.sv
// Input conditioning for the sequencer flag mux: N_IN independent
// synchronize/debounce channels with edge pulses and sticky rise events.
module flag_conditioner
    import flag_cond_pkg::*;
#(
    parameter int              N_IN      = 6,
    parameter int              DB_CYCLES = 1000000,
    parameter logic [N_IN-1:0] RST_LEVEL = '0
) (
    input  logic            ck,
    input  logic            rst_n,
    input  logic [N_IN-1:0] raw_in,
    input  logic [N_IN-1:0] evt_clr,
    output logic [N_IN-1:0] flag,
    output logic [N_IN-1:0] rise,
    output logic [N_IN-1:0] fall,
    output logic [N_IN-1:0] evt
);

    for (genvar i = 0; i < N_IN; i++) begin : g_ch
        flag_debounce_ch #(
            .DB_CYCLES (DB_CYCLES),
            .RST_BIT   (RST_LEVEL[i])
        ) u_ch (
            .ck      (ck),
            .rst_n   (rst_n),
            .raw     (raw_in[i]),
            .evt_clr (evt_clr[i]),
            .flag    (flag[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .evt     (evt[i])
        );
    end

endmodule

// File: tb/tb_flag_conditioner.sv
// Bench for flag_conditioner: run-length reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_flag_conditioner;
    import flag_cond_pkg::*;

    localparam int N  = 6;
    localparam int DB = 4;

    logic         ck = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] raw_in = '0;
    logic [N-1:0] evt_clr = '0;
    logic [N-1:0] flag, rise, fall, evt;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    flag_conditioner #(.N_IN(N), .DB_CYCLES(DB), .RST_LEVEL(6'b000000)) dut (
        .ck(ck), .rst_n(rst_n), .raw_in(raw_in), .evt_clr(evt_clr),
        .flag(flag), .rise(rise), .fall(fall), .evt(evt)
    );

    always #5 ck = ~ck;

    // Reference: raw is seen two edges late; the clean level flips once the
    // delayed input has disagreed with it for DB consecutive edges.
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_flag = '0, m_rise = '0, m_fall = '0, m_evt = '0;
    int           m_run [N];

    always @(posedge ck or negedge rst_n) begin
        logic [N-1:0] nf, nr, nfl;
        if (!rst_n) begin
            m_s1 <= '0; m_s2 <= '0; m_flag <= '0;
            m_rise <= '0; m_fall <= '0; m_evt <= '0;
            for (int i = 0; i < N; i++) m_run[i] <= 0;
        end else begin
            nf = m_flag; nr = '0; nfl = '0;
            for (int i = 0; i < N; i++) begin
                if (m_s2[i] != m_flag[i]) begin
                    if (m_run[i] + 1 >= DB) begin
                        nf[i] = ~m_flag[i];
                        nr[i] = ~m_flag[i];
                        nfl[i] = m_flag[i];
                        m_run[i] <= 0;
                    end else begin
                        m_run[i] <= m_run[i] + 1;
                    end
                end else begin
                    m_run[i] <= 0;
                end
            end
            m_s1 <= raw_in; m_s2 <= m_s1;
            m_flag <= nf; m_rise <= nr; m_fall <= nfl;
            m_evt <= nr | (m_evt & ~evt_clr);
        end
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge ck) begin
        if (chk_en) begin
            chk("flag", flag, m_flag);
            chk("rise", rise, m_rise);
            chk("fall", fall, m_fall);
            chk("evt",  evt,  m_evt);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    initial begin
        logic [N-1:0] seen;
        int           cyc;

        tick(2);
        chk_en = 1'b1;
        chk("reset flag", flag, 6'b000000);
        chk("reset evt",  evt,  6'b000000);
        rst_n = 1'b1;
        tick(20);
        chk("idle flag", flag, 6'b000000);
        chk("idle rise", rise, 6'b000000);

        // Step on SE: flag changes on the 6th edge counting the sampling edge.
        raw_in[CH_SE] = 1'b1;
        tick(5);
        chk("se pre flag", flag, 6'b000000);
        tick(1);
        chk("se flag edge6", flag, 6'b100000);
        chk("se rise edge6", rise, 6'b100000);
        tick(1);
        chk("se rise gone", rise, 6'b000000);
        chk("se evt sticky", evt, 6'b100000);

        // 3-cycle glitch on M is rejected; 5-cycle hold is accepted.
        seen = '0;
        raw_in[CH_M] = 1'b1; tick(3);
        raw_in[CH_M] = 1'b0;
        repeat (10) begin tick(1); seen |= flag | rise; end
        chk("glitch3 no flag", seen & 6'b000001, 6'b000000);
        raw_in[CH_M] = 1'b1; tick(5);
        raw_in[CH_M] = 1'b0; tick(1);
        chk("hold5 flag", flag & 6'b000001, 6'b000001);
        tick(10);

        // Clear the sticky event, then make a clear coincide with a new rise.
        evt_clr[CH_SE] = 1'b1; tick(1);
        evt_clr[CH_SE] = 1'b0;
        chk("evt cleared", evt & 6'b100000, 6'b000000);
        raw_in[CH_SE] = 1'b0; tick(8);
        raw_in[CH_SE] = 1'b1; tick(5);
        evt_clr[CH_SE] = 1'b1; tick(1);
        evt_clr[CH_SE] = 1'b0;
        chk("set wins rise", rise & 6'b100000, 6'b100000);
        chk("set wins evt",  evt  & 6'b100000, 6'b100000);
        tick(3);

        // LC high, then reset while its fall is being counted.
        raw_in[CH_LC] = 1'b1; tick(8);
        chk("lc high", flag & 6'b010000, 6'b010000);
        raw_in[CH_LC] = 1'b0; tick(4);
        rst_n = 1'b0; #1;
        chk("rst flag now", flag, 6'b000000);
        chk("rst fall now", fall, 6'b000000);
        tick(2);
        rst_n = 1'b1;
        seen = '0;
        repeat (10) begin tick(1); seen |= fall | rise; end
        chk("rst no pulse lc", seen & 6'b010000, 6'b000000);
        chk("rst se redone", flag, 6'b100000);

        // All channels together.
        raw_in = '0; tick(10);
        chk("all low", flag, 6'b000000);
        raw_in = 6'b111111; tick(5);
        chk("all pre", flag, 6'b000000);
        tick(1);
        chk("all rise", rise, 6'b111111);
        chk("all flag", flag, 6'b111111);
        tick(1);
        chk("all rise one", rise, 6'b000000);
        raw_in = '0; tick(6);
        chk("all fall", fall, 6'b111111);
        chk("all flag low", flag, 6'b000000);
        tick(2);

        // Random traffic: per-bit toggles near the debounce length, random
        // clears and occasional resets.
        for (cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 4) == 0) raw_in[i] = ~raw_in[i];
            evt_clr = N'($urandom & $urandom);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                tick($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            tick(1);
        end
        evt_clr = '0;
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
